// File: rtl/srg_pkg.sv
// Shared definitions for the universal shift register: operation codes
// and a helper classifying which operations advance the shift counter.
package srg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  function automatic logic is_shift_mode(input logic [2:0] m);
    logic r;
    case (m)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ffd_en_cell.sv
// Single-bit D flip-flop with clock enable, synchronous active-high reset
// and a per-instance reset value.
module ffd_en_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  logic q_q;

  // Storage bit: reset wins, otherwise capture d when enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= RESET_BIT;
    end else if (en) begin
      q_q <= d;
    end else begin
      q_q <= q_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: load, shift/rotate both ways, clear, with a
// serial output and a done pulse after every WIDTH shift/rotate operations.
module shift_reg_univ
  import srg_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    cnt_q;
  logic             sout_d;
  logic             sout_q;
  logic             done_d;
  logic             done_q;

  // Next-state selection for data, serial output and shift counter
  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (enable) begin
      case (mode)
        MODE_LOAD: begin
          q_d   = d;
          cnt_d = {CW{1'b0}};
        end
        MODE_SHL: begin
          q_d    = {q_q[WIDTH-2:0], sin};
          sout_d = q_q[WIDTH-1];
        end
        MODE_SHR: begin
          q_d    = {sin, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        MODE_ROL: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d = q_q[WIDTH-1];
        end
        MODE_ROR: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        MODE_CLR: begin
          q_d    = {WIDTH{1'b0}};
          sout_d = 1'b0;
          cnt_d  = {CW{1'b0}};
        end
        default: begin
          q_d = q_q;
        end
      endcase
      // Reaching WIDTH wraps straight to zero; done marks that edge
      if (is_shift_mode(mode)) begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d  = {CW{1'b0}};
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        done_d = 1'b0;
      end
    end else begin
      done_d = 1'b0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ffd_en_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (enable),
      .d     (q_d[i]),
      .q     (q_q[i])
    );
  end

  // Control state: serial output, shift counter, done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      sout_q <= 1'b0;
      cnt_q  <= {CW{1'b0}};
      done_q <= 1'b0;
    end else begin
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench: directed vector table, hand-written boundary sequences
// and randomized operations checked against an arithmetic reference model.
module tb_shift_reg_univ;
  import srg_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin;
  logic [W-1:0] q;
  logic         sout;
  logic         done;
  logic [W-1:0] q2;
  logic         sout2;
  logic         done2;

  int checks = 0;
  int failures = 0;

  // reference model state (plain integers)
  int mq = 0;
  int ms = 0;
  int mc = 0;
  int md = 0;

  typedef struct {
    logic         r;
    logic         e;
    logic [2:0]   m;
    logic [W-1:0] dd;
    logic         s;
    logic [W-1:0] xq;
    logic         xs;
    logic         xd;
  } vec_t;

  vec_t vecs[24];

  shift_reg_univ #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .d(d), .sin(sin), .q(q), .sout(sout), .done(done)
  );

  shift_reg_univ #(.WIDTH(W), .RESET_VAL(4'b1010)) dut_rv (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .d(d), .sin(sin), .q(q2), .sout(sout2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic [2:0] m,
                            input logic [W-1:0] dd, input logic s);
    int full;
    int top;
    int bot;
    full = 1 << W;
    top = mq / (full / 2);
    bot = mq % 2;
    md = 0;
    if (r) begin
      mq = 0; ms = 0; mc = 0;
    end else if (e) begin
      if (m == MODE_LOAD) begin
        mq = int'(dd); mc = 0;
      end else if (m == MODE_CLR) begin
        mq = 0; ms = 0; mc = 0;
      end else if (m >= MODE_SHL && m <= MODE_ROR) begin
        if (m == MODE_SHL) begin mq = (mq * 2 + int'(s)) % full; ms = top; end
        if (m == MODE_SHR) begin mq = mq / 2 + int'(s) * (full / 2); ms = bot; end
        if (m == MODE_ROL) begin mq = (mq * 2) % full + top; ms = top; end
        if (m == MODE_ROR) begin mq = mq / 2 + bot * (full / 2); ms = bot; end
        mc = mc + 1;
        if (mc == W) begin
          mc = 0; md = 1;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [2:0] m,
                       input logic [W-1:0] dd, input logic s);
    reset = r; enable = e; mode = m; d = dd; sin = s;
    model_step(r, e, m, dd, s);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"}, 32'(q), 32'(mq));
    check({tag, ".sout"}, 32'(sout), 32'(ms));
    check({tag, ".done"}, 32'(done), 32'(md));
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic [2:0] m,
                              input logic [W-1:0] dd, input logic s,
                              input logic [W-1:0] xq, input logic xs, input logic xd);
    vec_t v;
    v.r = r; v.e = e; v.m = m; v.dd = dd; v.s = s; v.xq = xq; v.xs = xs; v.xd = xd;
    return v;
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 3'b000; d = 4'b0000; sin = 1'b0;

    // reset (random mode/d), enable gating, serialise, deserialise, rotate
    vecs[0]  = mk(1'b1, 1'b1, 3'($urandom_range(7, 0)), 4'($urandom), 1'b1, 4'b0000, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 3'($urandom_range(7, 0)), 4'($urandom), 1'b0, 4'b0000, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, MODE_LOAD, 4'b1011, 1'b0, 4'b0000, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, MODE_LOAD, 4'b1011, 1'b0, 4'b1011, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b1, MODE_SHL,  4'b0000, 1'b0, 4'b0110, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 1'b1, MODE_SHL,  4'b0000, 1'b0, 4'b1100, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b1, MODE_SHL,  4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, MODE_SHL,  4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1);
    vecs[8]  = mk(1'b0, 1'b1, MODE_CLR,  4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, MODE_SHR,  4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, MODE_SHR,  4'b0000, 1'b1, 4'b1100, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 1'b1, MODE_SHR,  4'b0000, 1'b0, 4'b0110, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 1'b1, MODE_SHR,  4'b0000, 1'b1, 4'b1011, 1'b0, 1'b1);
    vecs[13] = mk(1'b0, 1'b1, MODE_SHR,  4'b0000, 1'b0, 4'b0101, 1'b1, 1'b0);
    vecs[14] = mk(1'b0, 1'b1, MODE_LOAD, 4'b1001, 1'b0, 4'b1001, 1'b1, 1'b0);
    vecs[15] = mk(1'b0, 1'b1, MODE_ROL,  4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0);
    vecs[16] = mk(1'b0, 1'b1, MODE_ROR,  4'b0000, 1'b0, 4'b1001, 1'b1, 1'b0);
    vecs[17] = mk(1'b0, 1'b1, MODE_LOAD, 4'b1001, 1'b0, 4'b1001, 1'b1, 1'b0);
    vecs[18] = mk(1'b0, 1'b1, MODE_ROL,  4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0);
    vecs[19] = mk(1'b0, 1'b1, MODE_ROL,  4'b0000, 1'b0, 4'b0110, 1'b0, 1'b0);
    vecs[20] = mk(1'b0, 1'b1, MODE_ROL,  4'b0000, 1'b0, 4'b1100, 1'b0, 1'b0);
    vecs[21] = mk(1'b0, 1'b1, MODE_ROL,  4'b0000, 1'b0, 4'b1001, 1'b1, 1'b1);
    vecs[22] = mk(1'b0, 1'b0, MODE_SHL,  4'b0000, 1'b1, 4'b1001, 1'b1, 1'b0);
    vecs[23] = mk(1'b0, 1'b1, MODE_RSVD, 4'b0110, 1'b1, 4'b1001, 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].r, vecs[i].e, vecs[i].m, vecs[i].dd, vecs[i].s);
      check($sformatf("vec%0d.q", i), 32'(q), 32'(vecs[i].xq));
      check($sformatf("vec%0d.sout", i), 32'(sout), 32'(vecs[i].xs));
      check($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].xd));
      if (vecs[i].r) begin
        check($sformatf("vec%0d.q_rv", i), 32'(q2), 32'hA);
        check($sformatf("vec%0d.sout_rv", i), 32'(sout2), 32'h0);
        check($sformatf("vec%0d.done_rv", i), 32'(done2), 32'h0);
      end
    end

    // abort mid-serialisation with reset, then LOAD on the WIDTH-1 edge
    drive(1'b0, 1'b1, MODE_LOAD, 4'b0110, 1'b0);
    check_model("abort.load");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, MODE_SHL, 4'b0000, 1'b0);
      check_model($sformatf("abort.shl%0d", i));
    end
    drive(1'b1, 1'b1, MODE_SHL, 4'b1111, 1'b1);
    check("abort.reset.q", 32'(q), 32'h0);
    check("abort.reset.done", 32'(done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, MODE_SHL, 4'b0000, 1'b1);
      check_model($sformatf("bnd.shl%0d", i));
    end
    drive(1'b0, 1'b1, MODE_LOAD, 4'b0110, 1'b0);
    check("bnd.load.done", 32'(done), 32'h0);
    drive(1'b0, 1'b1, MODE_SHL, 4'b0000, 1'b0);
    check("bnd.shl.done", 32'(done), 32'h0);
    check_model("bnd.shl");

    // randomized operations against the reference model
    for (int i = 0; i < 500; i++) begin
      logic r;
      logic e;
      r = ($urandom_range(40, 0) == 0);
      e = ($urandom_range(3, 0) != 0);
      drive(r, e, 3'($urandom_range(7, 0)), 4'($urandom), 1'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
